// File: rtl/led_pkg.sv
// led_pkg: shared state encoding and default sizing for the LED sequencer
package led_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam int DEF_TICK_DIV = 100000000;
  localparam int DEF_PRE_W = 27;
  localparam int DEF_LED_W = 4;
endpackage

// File: rtl/led_seq_ctrl_if.sv
// led_seq_ctrl_if: board buttons/switches in, LED display signals out
interface led_seq_ctrl_if
  import led_pkg::*;
#(
  parameter int LED_W = DEF_LED_W
);
  logic btn_start;
  logic btn_stop;
  logic btn_step;
  logic dir;
  logic [LED_W-1:0] limit;
  logic [LED_W-1:0] led;
  logic tick;
  logic wrap;
  logic running;
  modport master (
    output btn_start, btn_stop, btn_step, dir, limit,
    input led, tick, wrap, running
  );
  modport slave (
    input btn_start, btn_stop, btn_step, dir, limit,
    output led, tick, wrap, running
  );
endinterface

// File: rtl/btn_edge.sv
// btn_edge: two-flop synchroniser followed by a single-cycle rising-edge pulse
module btn_edge (
  input logic clk,
  input logic clr_n,
  input logic btn,
  output logic press
);
  logic sync1_q, sync2_q, prev_q;
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q <= sync2_q;
    end
  assign press = sync2_q & ~prev_q;
endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: run/pause/step sequencer owning the LED count, its prescaler
// and the wrap/direction advance rule
module led_seq_ctrl
  import led_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int PRE_W = DEF_PRE_W,
  parameter int LED_W = DEF_LED_W
) (
  input logic clk,
  input logic clr_n,
  led_seq_ctrl_if.slave bus
);
  logic start_p, stop_p, step_p, adv;
  logic [1:0] state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [LED_W-1:0] led_q, led_d;
  logic tick_q, tick_d, wrap_q, wrap_d, running_q, running_d;
  btn_edge u_start (.clk(clk), .clr_n(clr_n), .btn(bus.btn_start), .press(start_p));
  btn_edge u_stop (.clk(clk), .clr_n(clr_n), .btn(bus.btn_stop), .press(stop_p));
  btn_edge u_step (.clk(clk), .clr_n(clr_n), .btn(bus.btn_step), .press(step_p));
  // {wrap, next led}; a down count above a lowered limit clamps without wrapping
  function automatic logic [LED_W:0] next_led(input logic [LED_W-1:0] cur,
                                              input logic [LED_W-1:0] lim,
                                              input logic down);
    if (!down) return (cur >= lim) ? {1'b1, {LED_W{1'b0}}} : {1'b0, cur + LED_W'(1)};
    return (cur == '0) ? {1'b1, lim} : (cur > lim) ? {1'b0, lim} : {1'b0, cur - LED_W'(1)};
  endfunction
  always_comb begin
    state_d = state_q;
    pre_d = pre_q;
    led_d = led_q;
    adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        led_d = '0;
        pre_d = '0;
        state_d = (start_p && !stop_p) ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        // stop beats a coinciding terminal count, leaving the prescaler at TICK_DIV-1
        adv = !stop_p && (pre_q == PRE_W'(TICK_DIV - 1));
        pre_d = stop_p ? pre_q : adv ? '0 : pre_q + PRE_W'(1);
        state_d = stop_p ? ST_PAUSE : ST_RUN;
      end
      ST_PAUSE: begin
        adv = !stop_p && !start_p && step_p;
        state_d = stop_p ? ST_IDLE : start_p ? ST_RUN : ST_PAUSE;
        led_d = stop_p ? '0 : led_q;
        pre_d = stop_p ? '0 : pre_q;
      end
      default: begin
        state_d = ST_IDLE;
        led_d = '0;
        pre_d = '0;
      end
    endcase
    {wrap_d, led_d} = adv ? next_led(led_q, bus.limit, bus.dir) : {1'b0, led_d};
    tick_d = adv;
    running_d = state_d == ST_RUN;
  end
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) begin
      state_q <= ST_IDLE;
      pre_q <= '0;
      led_q <= '0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      led_q <= led_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      running_q <= running_d;
    end
  assign bus.led = led_q;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;
  assign bus.running = running_q;
endmodule
